dsm_mod_cifb: RTL and testbench



---
 rtl/dsm_pkg.sv | 15 +
 rtl/dsm_integrator_stage.sv | 26 ++
 rtl/dsm_mod_cifb.sv | 88 ++++++++
 tb/tb_dsm_mod_cifb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// dsm_pkg: shared constants and helpers for the CIFB delta-sigma modulator.
package dsm_pkg;
  localparam int DSM_COEF_DEFAULT [0:3] = '{16384, 16384, 16384, 16384};
  function automatic longint sat_w(input longint x, input int w);
    longint hi;
    hi = (longint'(1) <<< (w - 1)) - 1;
    return x > hi ? hi : x < -hi - 1 ? -hi - 1 : x;
  endfunction
  function automatic int clamp_lvl(input int r, input int m);
    return r > m ? m : r < -m ? -m : r;
  endfunction
  function automatic int qw_of(input int levels);
    return $clog2(levels) + 1;
  endfunction
endpackage

// File: rtl/dsm_integrator_stage.sv
// dsm_integrator_stage: one MAC-and-saturate loop integrator, s += (coef*(x-fb))>>>F.
module dsm_integrator_stage import dsm_pkg::*; #(
  parameter int W = 16,
  parameter int F = 14
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic signed [W-1:0] coef,
  input  logic signed [W-1:0] x,
  input  logic signed [W+1:0] fb,
  output logic signed [W-1:0] s
);
  logic signed [W-1:0] s_q, s_d;
  logic signed [W+1:0] diff, sum;
  logic signed [2*W+1:0] prod;
  always_comb begin
    diff = (W+2)'(x) - fb;
    prod = (2*W+2)'(coef) * (2*W+2)'(diff);
    sum = (W+2)'(s_q) + (W+2)'(prod >>> F);
    s_d = clr ? '0 : en ? W'(sat_w(longint'(sum), W)) : s_q;
  end
  always_ff @(posedge clock) s_q <= reset ? '0 : s_d;
  assign s = s_q;
endmodule

// File: rtl/dsm_mod_cifb.sv
// dsm_mod_cifb: N-th order CIFB delta-sigma modulator with multi-level quantizer,
// programmable coefficients and overload detection with automatic loop reset.
module dsm_mod_cifb import dsm_pkg::*; #(
  parameter int W          = 16,
  parameter int F          = 14,
  parameter int ORDER      = 2,
  parameter int LEVELS     = 3,
  parameter int STEP_SHIFT = 13,
  parameter int OVL_LIMIT  = 16,
  parameter int QW         = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [W-1:0]  vin,
  input  logic signed [W-1:0]  dith_i,
  input  logic                 dith_en,
  input  logic                 coef_we,
  input  logic [1:0]           coef_addr,
  input  logic signed [W-1:0]  coef_data,
  input  logic                 ovl_clr,
  output logic                 out_valid,
  output logic signed [QW-1:0] level,
  output logic                 clamped,
  output logic                 overload
);
  localparam int M  = (LEVELS - 1) / 2;
  localparam int RW = $clog2(OVL_LIMIT + 1);
  logic signed [W-1:0] s [ORDER];
  logic signed [W-1:0] c_q [ORDER];
  logic signed [W-1:0] c_d [ORDER];
  logic signed [QW-1:0] q_q, q_d;
  logic [RW-1:0] run_q, run_d;
  logic out_valid_q, out_valid_d, clamped_q, clamped_d, overload_q, overload_d;
  logic signed [W+1:0] fb, y, r;
  logic signed [W-1:0] dv;
  logic clamp_now, trip;
  int v;
  for (genvar k = 0; k < ORDER; k++) begin : g_stage
    dsm_integrator_stage #(.W(W), .F(F)) u_int (
      .clock,
      .reset,
      .en(in_valid),
      .clr(trip),
      .coef(c_q[k]),
      .x(k == 0 ? vin : s[k == 0 ? 0 : k - 1]),
      .fb,
      .s(s[k])
    );
  end
  always_comb begin
    fb = $signed({{(W+2-QW){q_q[QW-1]}}, q_q}) <<< STEP_SHIFT;
    dv = dith_en ? dith_i : '0;
    y = (W+2)'(s[ORDER-1]) + (W+2)'(vin) + (W+2)'(dv);
    r = (y + (W+2)'(1 <<< (STEP_SHIFT - 1))) >>> STEP_SHIFT;
    v = clamp_lvl(int'(r), M);
    clamp_now = int'(r) != v;
    // the sample that completes the clamp run clears the whole loop on the same edge
    trip = in_valid && clamp_now && run_q == RW'(OVL_LIMIT - 1);
    q_d = trip ? '0 : in_valid ? QW'(v) : q_q;
    run_d = trip ? '0 : !in_valid ? run_q : clamp_now ? run_q + RW'(1) : '0;
    out_valid_d = in_valid;
    clamped_d = in_valid ? clamp_now : clamped_q;
    overload_d = trip || (overload_q && !ovl_clr);
    c_d = c_q;
    for (int i = 0; i < ORDER; i++) if (coef_we && int'(coef_addr) == i) c_d[i] = coef_data;
  end
  always_ff @(posedge clock)
    if (reset) begin
      q_q <= '0;
      run_q <= '0;
      out_valid_q <= 1'b0;
      clamped_q <= 1'b0;
      overload_q <= 1'b0;
      for (int i = 0; i < ORDER; i++) c_q[i] <= W'(DSM_COEF_DEFAULT[i]);
    end else begin
      q_q <= q_d;
      run_q <= run_d;
      out_valid_q <= out_valid_d;
      clamped_q <= clamped_d;
      overload_q <= overload_d;
      c_q <= c_d;
    end
  assign out_valid = out_valid_q;
  assign level = q_q;
  assign clamped = clamped_q;
  assign overload = overload_q;
endmodule

// File: tb/tb_dsm_mod_cifb.sv
// tb_dsm_mod_cifb: directed stimulus with a golden-model scoreboard for dsm_mod_cifb.
module tb_dsm_mod_cifb;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic signed [15:0] vin = '0;
  logic signed [15:0] dith_i = '0;
  logic dith_en = 1'b0;
  logic coef_we = 1'b0;
  logic [1:0] coef_addr = '0;
  logic signed [15:0] coef_data = '0;
  logic ovl_clr = 1'b0;
  logic out_valid;
  logic signed [3:0] level;
  logic clamped, overload;

  dsm_mod_cifb dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .vin(vin), .dith_i(dith_i),
    .dith_en(dith_en), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .ovl_clr(ovl_clr), .out_valid(out_valid), .level(level), .clamped(clamped),
    .overload(overload)
  );

  always #5 clock = ~clock;

  typedef struct {logic signed [63:0] lvl; logic clp; logic ov;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic exp_ov = 1'b0;

  longint ms[2], mc[2], mq, mrun;
  bit mov;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wr(input longint x);
    logic signed [17:0] t;
    t = x[17:0];
    return longint'(t);
  endfunction

  function automatic longint sat16(input longint x);
    return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
  endfunction

  task automatic m_reset();
    ms = '{0, 0};
    mc = '{16384, 16384};
    mq = 0;
    mrun = 0;
    mov = 0;
  endtask

  task automatic m_step(input longint v, input longint d, output exp_t e, output bit tr);
    longint fb, x, t, y, r, lv;
    longint ns[2];
    fb = mq * 8192;
    for (int k = 0; k < 2; k++) begin
      x = (k == 0) ? v : ms[0];
      t = (mc[k] * wr(x - fb)) >>> 14;
      ns[k] = sat16(wr(ms[k] + t));
    end
    y = wr(ms[1] + v + d);
    r = wr(y + 4096) >>> 13;
    lv = r > 1 ? 1 : r < -1 ? -1 : r;
    e.clp = (r != lv);
    mrun = e.clp ? mrun + 1 : 0;
    tr = (mrun == 16);
    if (tr) begin
      ms = '{0, 0};
      mq = 0;
      mrun = 0;
      mov = 1;
    end else begin
      ms = ns;
      mq = lv;
    end
    e.lvl = mq;
    e.ov = mov;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit iv, input longint v, input longint d = 0, input bit we = 0,
                       input logic [1:0] a = 0, input longint cd = 0, input bit clr = 0);
    exp_t e;
    bit tr;
    tr = 0;
    in_valid = iv;
    vin = 16'(v);
    dith_i = 16'(d);
    dith_en = (d != 0);
    coef_we = we;
    coef_addr = a;
    coef_data = 16'(cd);
    ovl_clr = clr;
    if (iv) begin
      m_step(v, d, e, tr);
      sb.push_back(e);
    end
    if (we && a < 2) mc[a] = cd;
    if (clr && !tr) mov = 0;
    cyc();
    in_valid = 1'b0;
    coef_we = 1'b0;
    ovl_clr = 1'b0;
    dith_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m_reset();
  endtask

  always @(posedge clock) exp_ov <= in_valid && !reset;

  always @(negedge clock) begin
    exp_t e;
    chk("out_valid", out_valid, exp_ov);
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("level", level, e.lvl);
        chk("clamped", clamped, e.clp);
        chk("overload", overload, e.ov);
      end
    end
  end

  initial begin
    m_reset();
    cyc();
    do_reset();
    chk("rst_level", level, 0);
    chk("rst_clamped", clamped, 0);
    chk("rst_overload", overload, 0);
    chk("rst_out_valid", out_valid, 0);
    // zero input
    for (int i = 0; i < 100; i++) drive(1, 0);
    chk("zero_s0", dut.g_stage[0].u_int.s_q, 0);
    chk("zero_s1", dut.g_stage[1].u_int.s_q, 0);
    chk("zero_level", level, 0);
    // DC input
    do_reset();
    for (int i = 0; i < 512; i++) drive(1, 4096);
    // overload with full-scale input
    do_reset();
    for (int i = 0; i < 15; i++) drive(1, 32767);
    chk("ovl_before_trip", overload, 0);
    chk("clamp_before_trip", clamped, 1);
    drive(1, 32767);
    chk("ovl_trip", overload, 1);
    chk("ovl_level", level, 0);
    chk("ovl_s0", dut.g_stage[0].u_int.s_q, 0);
    chk("ovl_s1", dut.g_stage[1].u_int.s_q, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("ovl_clr", overload, 0);
    // coefficient write alongside a sample
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 3000);
    drive(1, 3000, 0, 1, 0, 8192);
    chk("coef0_written", dut.c_q[0], 8192);
    for (int i = 0; i < 5; i++) drive(1, 3000);
    drive(0, 0, 0, 1, 3, 123);
    chk("coef0_after_addr3", dut.c_q[0], 8192);
    chk("coef1_after_addr3", dut.c_q[1], 16384);
    for (int i = 0; i < 5; i++) drive(1, 3000);
    // gapped strobes, some with dither
    for (int i = 0; i < 10; i++) begin
      drive(1, 2000 + i * 500, (i % 2) ? 1000 : 0);
      drive(0, 0);
      chk("gap_level", level, mq);
      chk("gap_s0", dut.g_stage[0].u_int.s_q, ms[0]);
      drive(0, 0);
      chk("gap_s1", dut.g_stage[1].u_int.s_q, ms[1]);
    end
    // mid-run reset collides with a strobe
    for (int i = 0; i < 20; i++) drive(1, 5000);
    in_valid = 1'b1;
    vin = 16'sd5000;
    do_reset();
    in_valid = 1'b0;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_level", level, 0);
    chk("mrst_clamped", clamped, 0);
    chk("mrst_overload", overload, 0);
    chk("mrst_coef0", dut.c_q[0], 16384);
    chk("mrst_s0", dut.g_stage[0].u_int.s_q, 0);
    cyc();
    for (int i = 0; i < 4; i++) drive(1, 1000);
    cyc();
    cyc();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
